uart_rx_ovs: RTL and testbench

UART_RX_OVS -- requirements
Module: uart_rx_ovs

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_os_tick_gen.sv | 41 ++++
 rtl/uart_rx_ovs.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM state codes and the
// fractional baud increment used by the tick generator.
package uart_pkg;

  localparam int unsigned StW = 3;
  typedef logic [StW-1:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StStart  = 3'd1;
  localparam state_t StData   = 3'd2;
  localparam state_t StParity = 3'd3;
  localparam state_t StStop   = 3'd4;

  // Rounded BAUD*OVERSAMPLE*2^ACC_W/CLK_FREQ.
  function automatic longint unsigned uart_inc(input longint unsigned clk_freq,
                                               input longint unsigned baud,
                                               input longint unsigned oversample,
                                               input longint unsigned acc_w);
    longint unsigned num;
    num = baud * oversample * (64'd1 << acc_w);
    return (num + clk_freq / 2) / clk_freq;
  endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversample tick generator: phase accumulator whose carry-out is the sample tick.
module uart_os_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W      = 24
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam longint unsigned IncVal = uart_inc(longint'(CLK_FREQ), longint'(BAUD),
                                                longint'(OVERSAMPLE), longint'(ACC_W));
  localparam logic [ACC_W:0] Inc = IncVal[ACC_W:0];

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;
  logic             tick_q, tick_d;

  always_comb begin
    sum    = {1'b0, acc_q} + Inc;
    acc_d  = sum[ACC_W-1:0];
    tick_d = sum[ACC_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with 2-of-3 mid-bit majority vote and a one-entry holding
// register. Parity support is compiled in with macro UART_RX_PARITY_EN.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W      = 24
`ifdef UART_RX_PARITY_EN
  ,
  parameter int PARITY_ODD = 0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int CntW = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] SampA  = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] SampB  = CntW'(OVERSAMPLE / 2);
  localparam logic [CntW-1:0] SampC  = CntW'(OVERSAMPLE / 2 + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(OVERSAMPLE - 1);
  localparam logic [3:0]      LastBit  = 4'(DATA_BITS - 1);
  localparam logic            LastStop = (STOP_BITS == 2);

  logic tick;

  uart_os_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE),
    .ACC_W     (ACC_W)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  logic [1:0]           sync_q, sync_d;
  logic                 prev_q, prev_d;
  state_t               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [1:0]           samp_q, samp_d;
  logic [3:0]           bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
`endif

  logic rxs;
  logic maj;
  logic decide;

  assign rxs    = sync_q[1];
  assign sync_d = {sync_q[0], RxD};
  assign prev_d = rxs;

  // Third vote is the live sample taken on the deciding tick.
  assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
  assign decide = tick && (cnt_q == SampC) && (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    if (state_q == StIdle) begin
      if (prev_q && !rxs) begin
        state_d = StStart;
        cnt_d   = '0;
      end
    end else if (tick) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
      if (cnt_q == SampA) samp_d[0] = rxs;
      if (cnt_q == SampB) samp_d[1] = rxs;
    end

    // State changes happen mid-bit; the free-running count lines up the next bit.
    if (decide) begin
      case (state_q)
        StStart: begin
          if (maj) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            bit_d   = '0;
          end
        end
        StData: begin
          shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
          if (bit_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          par_bad_d = ((^shreg_q) ^ maj) != (PARITY_ODD != 0);
          state_d   = StStop;
          stop_d    = 1'b0;
        end
`endif
        StStop: begin
          if (!maj) begin
            ferr_d  = 1'b1;
            state_d = StIdle;
          end else if (stop_q == LastStop) begin
            state_d = StIdle;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) perr_d = 1'b1;
            else           done_d = 1'b1;
`else
            done_d = 1'b1;
`endif
          end else begin
            stop_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Holding register: a same-cycle transfer frees the slot for an incoming frame.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && rx_ready) valid_d = 1'b0;
    if (done_q) begin
      if (!valid_q || rx_ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= StIdle;
      cnt_q   <= '0;
      samp_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs: directed scenarios plus random frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_ovs;

  localparam int ClkFreq = 16000000;
  localparam int Baud    = 100000;
  localparam int Os      = 16;
  localparam int BitClk  = 160;

  logic       clk = 1'b0;
  logic       rst;
  logic       RxD;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  always #5 clk = ~clk;

  uart_rx_ovs #(
    .CLK_FREQ  (ClkFreq),
    .BAUD      (Baud),
    .DATA_BITS (8),
    .STOP_BITS (1),
    .OVERSAMPLE(Os),
    .ACC_W     (24)
`ifdef UART_RX_PARITY_EN
    ,
    .PARITY_ODD(0)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RxD       (RxD),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  int errors = 0;
  int checks = 0;

  // Frame-level model: expected deliveries and expected flag pulse counts.
  logic [7:0] exp_q[$];
  bit         model_full = 1'b0;
  int exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
  int act_ferr = 0, act_ovr = 0, act_perr = 0;
  int n_rx = 0;
  logic [7:0] last_rx = '0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Compare process: sampled 1ns after the falling edge, once per cycle.
  initial begin
    logic       pv, pr, pf, po, pp;
    logic [7:0] pd;
    pv = 0; pr = 0; pf = 0; po = 0; pp = 0; pd = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (rx_valid && rx_ready) begin
          check("rx_expected_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("rx_data", rx_data, exp_q.pop_front());
          last_rx = rx_data;
          n_rx++;
        end
        if (pv && !pr && rx_valid) check("hold_stable", rx_data, pd);
        if (pf) check("frame_err_one_cycle", frame_err, 0);
        if (po) check("overrun_one_cycle", overrun, 0);
        if (pp) check("parity_err_one_cycle", parity_err, 0);
        act_ferr += int'(frame_err);
        act_ovr  += int'(overrun);
        act_perr += int'(parity_err);
      end
      pv = rx_valid; pr = rx_ready; pd = rx_data;
      pf = frame_err; po = overrun; pp = parity_err;
    end
  end

  task automatic drive(input logic b);
    RxD = b;
    repeat (BitClk) @(negedge clk);
  endtask

  task automatic set_ready(input logic r);
    rx_ready = r;
    if (r) model_full = 1'b0;
  endtask

  task automatic check_counts();
    check("frame_err_count", act_ferr, exp_ferr);
    check("overrun_count", act_ovr, exp_ovr);
    check("parity_err_count", act_perr, exp_perr);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    logic good;
    good = stop_ok;
    if (!stop_ok) exp_ferr++;
`ifdef UART_RX_PARITY_EN
    else if (!par_ok) begin
      exp_perr++;
      good = 1'b0;
    end
`endif
    if (good) begin
      if (model_full && !rx_ready) begin
        exp_ovr++;
      end else begin
        exp_q.push_back(d);
        model_full = !rx_ready;
      end
    end
    drive(1'b0);
    for (int i = 0; i < 8; i++) drive(d[i]);
`ifdef UART_RX_PARITY_EN
    drive((^d) ^ !par_ok);
`endif
    drive(stop_ok);
    RxD = 1'b1;
    if (!stop_ok) drive(1'b1);
    check_counts();
  endtask

  initial begin
    int base;
    logic [7:0] d;
    rst = 1'b1;
    RxD = 1'b1;
    rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_parity_err", parity_err, 0);
    rst = 1'b0;
    repeat (2 * BitClk) @(negedge clk);

    // Single frame, consumer ready.
    base = n_rx;
    send_frame(8'hA5, 1'b1, 1'b1);
    check("a5_count", n_rx - base, 1);
    check("a5_data", last_rx, 8'hA5);

    // Short low glitch is a false start.
    base = n_rx;
    RxD = 1'b0;
    repeat (60) @(negedge clk);
    RxD = 1'b1;
    repeat (2 * BitClk) @(negedge clk);
    check("glitch_no_rx", n_rx - base, 0);
    check("glitch_no_valid", rx_valid, 0);
    check_counts();

    // Stop bit low.
    base = act_ferr;
    send_frame(8'h3C, 1'b0, 1'b1);
    check("3c_frame_err_pulses", act_ferr - base, 1);
    check("3c_no_valid", rx_valid, 0);

    // Back-to-back with consumer stalled: second frame overruns.
    set_ready(1'b0);
    base = act_ovr;
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    repeat (BitClk) @(negedge clk);
    check("ovr_pulses", act_ovr - base, 1);
    check("ovr_held_valid", rx_valid, 1);
    check("ovr_held_data", rx_data, 8'h11);
    set_ready(1'b1);
    repeat (10) @(negedge clk);
    check("ovr_transferred", last_rx, 8'h11);
    check("ovr_valid_cleared", rx_valid, 0);

`ifdef UART_RX_PARITY_EN
    base = act_perr;
    send_frame(8'h07, 1'b1, 1'b0);
    check("par_err_pulses", act_perr - base, 1);
    check("par_err_no_valid", rx_valid, 0);
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_ok_data", last_rx, 8'h07);
`endif

    // Random frames, random stalls and gaps.
    for (int k = 0; k < 14; k++) begin
      set_ready($urandom_range(0, 2) != 0);
      d = 8'($urandom_range(0, 255));
      send_frame(d, $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0);
      repeat ($urandom_range(0, 100)) @(negedge clk);
    end
    set_ready(1'b1);
    repeat (50) @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_valid_low", rx_valid, 0);

    // Reset in the middle of data bit 4, then a clean frame.
    d = 8'hC3;
    RxD = 1'b0;
    repeat (BitClk) @(negedge clk);
    for (int i = 0; i < 4; i++) drive(d[i]);
    RxD = d[4];
    repeat (BitClk / 2) @(negedge clk);
    rst = 1'b1;
    RxD = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_parity_err", parity_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BitClk) @(negedge clk);
    check_counts();
    base = n_rx;
    send_frame(8'h5A, 1'b1, 1'b1);
    check("5a_count", n_rx - base, 1);
    check("5a_data", last_rx, 8'h5A);
    repeat (20) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
